// File: rtl/flap_pkg.sv
// Shared constants and state encoding for the flap_sprite bird.
package flap_pkg;

  localparam int unsigned POS_W = 11;
  localparam int unsigned VEL_W = 6;

  typedef enum logic [1:0] {
    FS_READY   = 2'd0,
    FS_FLY     = 2'd1,
    FS_CRASHED = 2'd2
  } flap_state_e;

  localparam logic [1:0] ST_READY   = 2'd0;
  localparam logic [1:0] ST_FLY     = 2'd1;
  localparam logic [1:0] ST_CRASHED = 2'd2;

  localparam int unsigned SPR_X_DEF    = 160;
  localparam int unsigned SPR_W_DEF    = 16;
  localparam int unsigned SPR_H_DEF    = 16;
  localparam int unsigned Y_START_DEF  = 232;
  localparam int unsigned SCREEN_H_DEF = 480;
  localparam int unsigned GRAVITY_DEF  = 1;
  localparam int          FLAP_VEL_DEF = -8;
  localparam int unsigned VMAX_DEF     = 8;

endpackage

// File: rtl/flap_sync.sv
// Two-flop synchronizer for the raw flap button plus a one-cycle rising-edge pulse.
module flap_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rise
);

  logic sync0_q;
  logic sync1_q;
  logic prev_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      prev_q  <= 1'b0;
      o_rise  <= 1'b0;
    end else begin
      sync0_q <= i_btn;
      sync1_q <= sync0_q;
      prev_q  <= sync1_q;
      o_rise  <= sync1_q & ~prev_q;
    end
  end

endmodule

// File: rtl/flap_sprite.sv
// Flappy-bird style sprite: button-driven vertical physics, once-per-frame update,
// and a registered pixel-inside-sprite flag for the video path.
module flap_sprite
  import flap_pkg::*;
#(
  parameter int unsigned SPR_X    = SPR_X_DEF,
  parameter int unsigned SPR_W    = SPR_W_DEF,
  parameter int unsigned SPR_H    = SPR_H_DEF,
  parameter int unsigned Y_START  = Y_START_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF,
  parameter int unsigned GRAVITY  = GRAVITY_DEF,
  parameter int          FLAP_VEL = FLAP_VEL_DEF,
  parameter int unsigned VMAX     = VMAX_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_stb,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  input  logic       i_anim,
  input  logic       i_flap,
  output logic       o_sprite,
  output logic [8:0] o_y_pos,
  output logic [1:0] o_state,
  output logic       o_crash
);

  localparam logic signed [POS_W-1:0] Y_ST   = POS_W'(Y_START);
  localparam logic signed [POS_W-1:0] FLOOR  = POS_W'(SCREEN_H - SPR_H);
  localparam logic signed [VEL_W-1:0] FLAP_V = VEL_W'(FLAP_VEL);
  localparam logic signed [VEL_W:0]   GRAV_E = (VEL_W+1)'(GRAVITY);
  localparam logic signed [VEL_W:0]   VMAX_E = (VEL_W+1)'(VMAX);
  localparam logic [9:0]              X_LO   = 10'(SPR_X);
  localparam logic [9:0]              X_HI   = 10'(SPR_X + SPR_W);

  logic                    rise;
  logic [1:0]              state_q, state_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic                    pend_q, pend_d;
  logic                    crash_d;
  logic signed [VEL_W-1:0] v_use;
  logic signed [POS_W-1:0] y_next;
  logic signed [VEL_W:0]   v_inc;
  logic signed [VEL_W-1:0] v_lim;
  logic [POS_W-1:0]        pos_u;
  logic [POS_W-1:0]        y_hi;
  logic [POS_W-1:0]        y_ext;
  logic                    in_x_c;
  logic                    in_y_c;

  flap_sync u_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_btn  (i_flap),
    .o_rise (rise)
  );

  // Next-state physics; a flap edge coinciding with the frame pulse counts as pending.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    vel_d   = vel_q;
    pend_d  = pend_q;
    crash_d = 1'b0;
    v_use   = (pend_q || rise) ? FLAP_V : vel_q;
    y_next  = pos_q + signed'({{(POS_W-VEL_W){v_use[VEL_W-1]}}, v_use});
    v_inc   = signed'({v_use[VEL_W-1], v_use}) + GRAV_E;
    v_lim   = (v_inc > VMAX_E) ? VMAX_E[VEL_W-1:0] : v_inc[VEL_W-1:0];
    case (state_q)
      ST_READY: begin
        pos_d = Y_ST;
        vel_d = '0;
        if (rise) begin
          state_d = ST_FLY;
          vel_d   = FLAP_V;
          pend_d  = 1'b0;
        end
      end
      ST_FLY: begin
        if (i_anim) begin
          pend_d = 1'b0;
          if (y_next[POS_W-1]) begin
            pos_d = '0;
            vel_d = '0;
          end else if (y_next >= FLOOR) begin
            pos_d   = FLOOR;
            vel_d   = '0;
            state_d = ST_CRASHED;
            crash_d = 1'b1;
          end else begin
            pos_d = y_next;
            vel_d = v_lim;
          end
        end else if (rise) begin
          pend_d = 1'b1;
        end
      end
      ST_CRASHED: begin
        if (rise) begin
          state_d = ST_READY;
          pos_d   = Y_ST;
          vel_d   = '0;
          pend_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_READY;
        pos_d   = Y_ST;
        vel_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_READY;
      pos_q   <= Y_ST;
      vel_q   <= '0;
      pend_q  <= 1'b0;
      o_crash <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      vel_q   <= vel_d;
      pend_q  <= pend_d;
      o_crash <= crash_d;
    end
  end

  // Pixel hit test; position is never negative so an unsigned view is safe.
  assign pos_u  = pos_q;
  assign y_hi   = pos_u + POS_W'(SPR_H);
  assign y_ext  = {2'b00, i_y};
  assign in_x_c = (i_x >= X_LO) && (i_x < X_HI);
  assign in_y_c = (y_ext >= pos_u) && (y_ext < y_hi);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sprite <= 1'b0;
    end else if (i_pix_stb) begin
      o_sprite <= in_x_c && in_y_c;
    end
  end

  assign o_y_pos = pos_q[8:0];
  assign o_state = state_q;

endmodule

// File: tb/tb_flap_sprite.sv
// Self-checking bench for flap_sprite: scoreboard of expected state/position plus a sprite hit table.
module tb_flap_sprite;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_pix_stb = 1'b0;
  logic [9:0] i_x = '0;
  logic [8:0] i_y = '0;
  logic       i_anim = 1'b0;
  logic       i_flap = 1'b0;
  logic       o_sprite;
  logic [8:0] o_y_pos;
  logic [1:0] o_state;
  logic       o_crash;

  always #5 i_clk = ~i_clk;

  flap_sprite dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_pix_stb (i_pix_stb),
    .i_x       (i_x),
    .i_y       (i_y),
    .i_anim    (i_anim),
    .i_flap    (i_flap),
    .o_sprite  (o_sprite),
    .o_y_pos   (o_y_pos),
    .o_state   (o_state),
    .o_crash   (o_crash)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic [8:0] y;
    logic       crash;
  } exp_t;

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic       hit;
  } spr_vec_t;

  exp_t sbq[$];
  logic spq[$];

  // Reference model of the bird
  int sm;
  int ym;
  int vm;
  int pm;

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic model_reset();
    sm = 0; ym = 232; vm = 0; pm = 0;
  endtask

  task automatic push(string n, logic crash);
    exp_t e;
    e.name = n; e.st = 2'(sm); e.y = 9'(ym); e.crash = crash;
    sbq.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty");
    end else begin
      e = sbq.pop_front();
      if (o_state !== e.st || o_y_pos !== e.y || o_crash !== e.crash) begin
        errors++;
        $display("FAIL %s: got state=%0d y=%0d crash=%0d, expected state=%0d y=%0d crash=%0d",
                 e.name, o_state, o_y_pos, o_crash, e.st, e.y, e.crash);
      end
    end
  endtask

  task automatic check_val(string n, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    model_reset();
    push("reset", 1'b0);
    pop_check();
    check_val("reset_sprite", int'(o_sprite), 0);
  endtask

  task automatic flap_press(string n);
    i_flap = 1'b1;
    repeat (6) tick();
    i_flap = 1'b0;
    repeat (4) tick();
    if (sm == 0) begin
      sm = 1; vm = -8; pm = 0;
    end else if (sm == 1) begin
      pm = 1;
    end else begin
      sm = 0; ym = 232; vm = 0; pm = 0;
    end
    push(n, 1'b0);
    pop_check();
  endtask

  task automatic model_anim(output logic crash);
    int vu, yn, vn;
    crash = 1'b0;
    if (sm == 1) begin
      vu = (pm != 0) ? -8 : vm;
      yn = ym + vu;
      vn = vu + 1;
      if (vn > 8) vn = 8;
      pm = 0;
      if (yn < 0) begin
        ym = 0; vm = 0;
      end else if (yn >= 464) begin
        ym = 464; vm = 0; sm = 2; crash = 1'b1;
      end else begin
        ym = yn; vm = vn;
      end
    end
  endtask

  task automatic anim(string n);
    logic c;
    model_anim(c);
    push(n, c);
    i_anim = 1'b1;
    tick();
    i_anim = 1'b0;
    pop_check();
    if (c) begin
      tick();
      check_val({n, "_crash_width"}, int'(o_crash), 0);
    end
  endtask

  task automatic fly_to_crash();
    flap_press("fly_start");
    for (int k = 0; k < 60 && sm != 2; k++) anim("fall");
  endtask

  spr_vec_t svec[6];

  initial begin
    logic c;
    svec[0] = '{x: 10'd160, y: 9'd232, hit: 1'b1};
    svec[1] = '{x: 10'd176, y: 9'd232, hit: 1'b0};
    svec[2] = '{x: 10'd160, y: 9'd248, hit: 1'b0};
    svec[3] = '{x: 10'd159, y: 9'd240, hit: 1'b0};
    svec[4] = '{x: 10'd168, y: 9'd231, hit: 1'b0};
    svec[5] = '{x: 10'd175, y: 9'd247, hit: 1'b1};

    tick();
    do_reset();

    // READY ignores frame pulses
    for (int k = 0; k < 3; k++) anim("ready_anim");
    check_val("ready_y", int'(o_y_pos), 232);
    check_val("ready_state", int'(o_state), 0);

    for (int i = 0; i < 6; i++) begin
      i_x = svec[i].x; i_y = svec[i].y; i_pix_stb = 1'b1;
      spq.push_back(svec[i].hit);
      tick();
      i_pix_stb = 1'b0;
      checks++;
      if (o_sprite !== spq[0]) begin
        errors++;
        $display("FAIL sprite[%0d]: got %0b expected %0b", i, o_sprite, spq[0]);
      end
      void'(spq.pop_front());
    end
    // No strobe: hit flag must hold
    i_x = 10'd0; i_y = 9'd0;
    repeat (2) tick();
    check_val("sprite_hold", int'(o_sprite), 1);

    // Single flap then free fall to the floor
    flap_press("flap_ready");
    check_val("fly_state", int'(o_state), 1);
    for (int k = 1; k <= 46; k++) begin
      model_anim(c);
      push("fall", c);
      i_anim = 1'b1;
      tick();
      i_anim = 1'b0;
      pop_check();
      if (k == 1) check_val("fall_y1", int'(o_y_pos), 224);
      if (k == 8) check_val("fall_y8", int'(o_y_pos), 196);
      if (k == 45) check_val("fall_nocrash45", int'(o_crash), 0);
      if (k == 46) begin
        check_val("fall_crash46", int'(o_crash), 1);
        check_val("fall_y46", int'(o_y_pos), 464);
        check_val("fall_state46", int'(o_state), 2);
        tick();
        check_val("crash_width", int'(o_crash), 0);
      end
    end

    anim("crashed_anim_ignored");
    check_val("crashed_y", int'(o_y_pos), 464);
    flap_press("crashed_flap");
    check_val("restart_y", int'(o_y_pos), 232);

    // Flap edge coinciding with the frame pulse
    flap_press("flap2");
    for (int k = 0; k < 10; k++) anim("coast");
    check_val("coast_y", int'(o_y_pos), 197);
    i_flap = 1'b1;
    repeat (3) tick();
    pm = 1;
    model_anim(c);
    push("same_cycle", c);
    i_anim = 1'b1;
    tick();
    i_anim = 1'b0;
    pop_check();
    check_val("same_cycle_y", int'(o_y_pos), 189);
    i_flap = 1'b0;
    repeat (4) tick();
    anim("after_same");
    check_val("after_same_y", int'(o_y_pos), 182);

    // Mid-flight reset overrides the frame pulse
    i_rst = 1'b1; i_anim = 1'b1;
    tick();
    i_rst = 1'b0; i_anim = 1'b0;
    model_reset();
    push("mid_reset", 1'b0);
    pop_check();

    // Flap before every frame: climb into the ceiling
    for (int k = 1; k <= 30; k++) begin
      flap_press("climb_flap");
      anim("climb");
      if (k == 29) check_val("ceiling_y29", int'(o_y_pos), 0);
      if (k == 30) begin
        check_val("ceiling_y30", int'(o_y_pos), 0);
        check_val("ceiling_state30", int'(o_state), 1);
      end
    end

    // Reset in CRASHED together with a flap edge and frame pulse
    do_reset();
    fly_to_crash();
    check_val("crash_again_state", int'(o_state), 2);
    i_flap = 1'b1;
    repeat (3) tick();
    i_rst = 1'b1; i_anim = 1'b1; i_flap = 1'b0;
    tick();
    i_rst = 1'b0; i_anim = 1'b0;
    model_reset();
    push("crash_reset", 1'b0);
    pop_check();
    repeat (8) tick();
    push("crash_reset_settle", 1'b0);
    pop_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
